// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU datapath and its downstream capture stage.
package alu_pkg;

   localparam int ALU_DATA_W = 8;
   localparam int ALU_FUNC_W = 2;

   typedef enum logic [1:0] {
      FN_ADD = 2'b00,
      FN_OR  = 2'b01,
      FN_AND = 2'b10,
      FN_CAT = 2'b11
   } alu_func_t;

   typedef struct packed {
      alu_func_t   func;
      logic [7:0]  result;
   } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo_sat_counter.sv
// Up-counter with synchronous active-low clear that holds at all-ones once reached.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   output logic [W-1:0] value
);

   logic [W-1:0] value_r;
   logic         at_max_s;

   // Saturation detect
   always_comb begin
      at_max_s = (value_r == {W{1'b1}});
   end

   // Count register: clear wins, then increment unless saturated
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         value_r <= {W{1'b0}};
      end else if (en && !at_max_s) begin
         value_r <= value_r + W'(1'b1);
      end else begin
         value_r <= value_r;
      end
   end

   assign value = value_r;

endmodule

// File: rtl/alu_result_fifo.sv
// Captures {Function, ALUout} samples into a small show-ahead FIFO drained over
// valid/ready; samples arriving while full are dropped and counted.
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = ALU_DATA_W,
   parameter int FUNC_W = ALU_FUNC_W,
   parameter int DROP_W = 8
) (
   input  logic                      Clock,
   input  logic                      Reset_b,
   input  logic [DATA_W-1:0]         ALUout,
   input  logic [FUNC_W-1:0]         Function,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [FUNC_W+DATA_W-1:0]  out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    count,
   output logic [DROP_W-1:0]         drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = FUNC_W + DATA_W;

   logic [ENT_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   logic full_s;
   logic empty_s;
   logic push_s;
   logic pop_s;
   logic drop_s;

   // Handshake decode; full/empty come from the occupancy count so in_ready
   // never sees out_ready, and a full FIFO refuses a push even while popping.
   always_comb begin
      full_s  = (count_r == CNT_W'(DEPTH));
      empty_s = (count_r == {CNT_W{1'b0}});
      push_s  = in_valid && !full_s;
      pop_s   = out_ready && !empty_s;
      drop_s  = in_valid && full_s;
   end

   // Pointer and occupancy state
   always_ff @(posedge Clock) begin
      if (!Reset_b) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are don't-care after reset
   always_ff @(posedge Clock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {Function, ALUout};
      end
   end

   // Show-ahead head entry, forced to zero while empty
   always_comb begin
      if (!empty_s) begin
         out_data = mem_r[rd_ptr_r];
      end else begin
         out_data = {ENT_W{1'b0}};
      end
   end

   assign in_ready  = !full_s;
   assign out_valid = !empty_s;
   assign count     = count_r;

   sat_counter #(
      .W (DROP_W)
   ) u_drop_counter (
      .clk   (Clock),
      .clr_n (Reset_b),
      .en    (drop_s),
      .value (drop_count)
   );

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: expected entries go into a scoreboard queue
// at push time and a negedge monitor pops and compares on every handshake.
module tb_alu_result_fifo;
   import alu_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset_b;
   logic [7:0] ALUout;
   logic [1:0] Function;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] count;
   logic [7:0] drop_count;

   int checks = 0;
   int errors = 0;
   logic [9:0] sb[$];
   logic [9:0] fill_exp [4] = '{10'h001, 10'h102, 10'h203, 10'h304};

   alu_result_fifo dut (
      .Clock      (Clock),
      .Reset_b    (Reset_b),
      .ALUout     (ALUout),
      .Function   (Function),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count      (count),
      .drop_count (drop_count)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic settle();
      @(negedge Clock);
   endtask

   // Monitor: every handshake consumes the oldest expected entry
   always @(negedge Clock) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got %0h expected no entry", out_data);
         end else begin
            check("sb_data", {22'd0, out_data}, {22'd0, sb.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      alu_entry_t e;

      // Reset held for two edges with a capture request pending
      Reset_b = 1'b0; in_valid = 1'b1; ALUout = 8'h55; Function = 2'b11; out_ready = 1'b0;
      repeat (2) tick();
      Reset_b = 1'b1; in_valid = 1'b0;
      settle();
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_drop", {24'd0, drop_count}, 32'd0);
      check("rst_out_data", {22'd0, out_data}, 32'd0);

      // Single pass
      tick();
      ALUout = 8'h13; Function = FN_ADD; in_valid = 1'b1; sb.push_back(10'h013);
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      settle();
      check("single_valid", {31'd0, out_valid}, 32'd1);
      check("single_data", {22'd0, out_data}, 32'h013);
      tick();
      out_ready = 1'b0;
      settle();
      check("single_empty", {31'd0, out_valid}, 32'd0);
      check("single_count", {29'd0, count}, 32'd0);

      // Fill to full
      tick();
      for (int i = 0; i < 4; i++) begin
         ALUout = 8'(i + 1); Function = 2'(i); in_valid = 1'b1;
         sb.push_back(fill_exp[i]);
         tick();
      end
      in_valid = 1'b0;
      settle();
      check("fill_count", {29'd0, count}, 32'd4);
      check("fill_in_ready", {31'd0, in_ready}, 32'd0);

      // Overflow: three drops, then saturation
      tick();
      for (int i = 0; i < 3; i++) begin
         ALUout = 8'hEE; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      settle();
      check("drop_3", {24'd0, drop_count}, 32'd3);
      check("drop_count_held", {29'd0, count}, 32'd4);
      check("drop_head", {22'd0, out_data}, 32'h001);
      tick();
      in_valid = 1'b1;
      repeat (300) tick();
      in_valid = 1'b0;
      settle();
      check("drop_sat", {24'd0, drop_count}, 32'hFF);

      // Full with simultaneous pop: push still refused
      tick();
      ALUout = 8'h77; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      settle();
      check("full_pop_count", {29'd0, count}, 32'd3);
      check("full_pop_head", {22'd0, out_data}, 32'h102);
      check("full_pop_drop", {24'd0, drop_count}, 32'hFF);
      tick();
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      settle();
      check("drain_count", {29'd0, count}, 32'd0);

      // Concurrent push/pop at occupancy 2 across pointer wrap
      tick();
      for (int k = 0; k < 2; k++) begin
         ALUout = 8'(8'h10 + k); Function = FN_OR; in_valid = 1'b1;
         sb.push_back({2'b01, 8'(8'h10 + k)});
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         ALUout = 8'(8'h20 + i); Function = 2'(i); in_valid = 1'b1; out_ready = 1'b1;
         e.func = alu_func_t'(2'(i));
         e.result = 8'(8'h20 + i);
         sb.push_back(e);
         settle();
         check("conc_count", {29'd0, count}, 32'd2);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      settle();
      check("conc_count_end", {29'd0, count}, 32'd2);
      tick();
      out_ready = 1'b1;
      repeat (2) tick();
      out_ready = 1'b0;
      settle();
      check("conc_drained", {29'd0, count}, 32'd0);
      check("conc_sb_empty", 32'(sb.size()), 32'd0);

      // Reset mid-stream discards entries
      tick();
      for (int k = 0; k < 3; k++) begin
         ALUout = 8'(8'h30 + k); Function = FN_AND; in_valid = 1'b1;
         sb.push_back({2'b10, 8'(8'h30 + k)});
         tick();
      end
      in_valid = 1'b0;
      settle();
      check("mid_count", {29'd0, count}, 32'd3);
      tick();
      Reset_b = 1'b0;
      sb.delete();
      tick();
      Reset_b = 1'b1;
      settle();
      check("mid_rst_count", {29'd0, count}, 32'd0);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_drop", {24'd0, drop_count}, 32'd0);
      tick();
      ALUout = 8'hAA; Function = FN_ADD; in_valid = 1'b1;
      sb.push_back(10'h0AA);
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      settle();
      check("post_rst_data", {22'd0, out_data}, 32'h0AA);
      tick();
      out_ready = 1'b0;
      settle();
      check("post_rst_count", {29'd0, count}, 32'd0);
      check("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
